// File: rtl/bram_port_arbiter_if.sv
// Bus bundle for bram_port_arbiter: host strobes, core handshake and the DATA BRAM port.
// With ARB_STALL_COUNT_EN defined it also carries the core stall counter and its clear.
interface bram_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 64
);
   logic                  host_lock_in;
   logic [ADDR_WIDTH-1:0] host_addr_in;
   logic [DATA_WIDTH-1:0] host_wdata_in;
   logic                  host_we_in;
   logic                  host_re_in;
   logic [DATA_WIDTH-1:0] host_rdata_out;
   logic                  host_rvalid_out;

   logic                  core_req_in;
   logic                  core_we_in;
   logic [ADDR_WIDTH-1:0] core_addr_in;
   logic [DATA_WIDTH-1:0] core_wdata_in;
   logic                  core_lock_in;
   logic                  core_grant_out;
   logic [DATA_WIDTH-1:0] core_rdata_out;
   logic                  core_rvalid_out;
   logic                  core_preempted_out;

   logic [ADDR_WIDTH-1:0] bram_addr_out;
   logic [DATA_WIDTH-1:0] bram_wdata_out;
   logic                  bram_we_out;
   logic                  bram_en_out;
   logic [DATA_WIDTH-1:0] bram_rdata_in;

`ifdef ARB_STALL_COUNT_EN
   logic                  stall_count_clr_in;
   logic [31:0]           core_stall_count_out;
`endif

   // Arbiter side
   modport slave (
`ifdef ARB_STALL_COUNT_EN
      input  stall_count_clr_in,
      output core_stall_count_out,
`endif
      input  host_lock_in, host_addr_in, host_wdata_in, host_we_in, host_re_in,
      output host_rdata_out, host_rvalid_out,
      input  core_req_in, core_we_in, core_addr_in, core_wdata_in, core_lock_in,
      output core_grant_out, core_rdata_out, core_rvalid_out, core_preempted_out,
      output bram_addr_out, bram_wdata_out, bram_we_out, bram_en_out,
      input  bram_rdata_in
   );

   // Environment side (comms, inference engine and BRAM)
   modport master (
`ifdef ARB_STALL_COUNT_EN
      output stall_count_clr_in,
      input  core_stall_count_out,
`endif
      output host_lock_in, host_addr_in, host_wdata_in, host_we_in, host_re_in,
      input  host_rdata_out, host_rvalid_out,
      output core_req_in, core_we_in, core_addr_in, core_wdata_in, core_lock_in,
      input  core_grant_out, core_rdata_out, core_rvalid_out, core_preempted_out,
      input  bram_addr_out, bram_wdata_out, bram_we_out, bram_en_out,
      output bram_rdata_in
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for the DATA BRAM port: host (never stalled) over core (req/grant).
// Optional macro ARB_STALL_COUNT_EN adds a saturating core stall counter with sync clear.
module bram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 14,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned READ_LATENCY = 2
) (
   input logic                clk_in,
   input logic                rst_in,
   bram_port_arbiter_if.slave bus
);
   localparam int unsigned LAST_STAGE = READ_LATENCY - 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CORE     = 2'd1,
      ST_HOST     = 2'd2,
      ST_HANDBACK = 2'd3
   } state_e;

   typedef struct packed {
      logic valid;
      logic to_core;
   } tag_t;

   state_e                    state_q;
   tag_t [READ_LATENCY-1:0]   tag_q;
   tag_t                      tag_d;

   logic                      host_access;
   logic                      core_grant;
   logic                      bram_en;
   logic                      bram_we;
   logic [ADDR_WIDTH-1:0]     bram_addr;
   logic [DATA_WIDTH-1:0]     bram_wdata;

   logic [DATA_WIDTH-1:0]     host_rdata_q;
   logic                      host_rvalid_q;
   logic [DATA_WIDTH-1:0]     core_rdata_q;
   logic                      core_rvalid_q;
   logic                      preempted_q;

   // Winner selection and BRAM command mux; gated by reset so the port is quiet in reset
   always_comb begin
      host_access = bus.host_we_in | bus.host_re_in;
      core_grant  = rst_in & bus.core_req_in & ~bus.host_lock_in & ~host_access &
                    ((state_q == ST_IDLE) | (state_q == ST_CORE));
      bram_en     = 1'b0;
      bram_we     = 1'b0;
      bram_addr   = '0;
      bram_wdata  = '0;
      tag_d       = '0;
      if (rst_in & host_access) begin
         bram_en       = 1'b1;
         bram_we       = bus.host_we_in;
         bram_addr     = bus.host_addr_in;
         bram_wdata    = bus.host_wdata_in;
         tag_d.valid   = ~bus.host_we_in;
         tag_d.to_core = 1'b0;
      end else if (core_grant) begin
         bram_en       = 1'b1;
         bram_we       = bus.core_we_in;
         bram_addr     = bus.core_addr_in;
         bram_wdata    = bus.core_wdata_in;
         tag_d.valid   = ~bus.core_we_in;
         tag_d.to_core = 1'b1;
      end
   end

   // Tag pipeline tracks each read's owner alongside the BRAM latency
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Capture douta for the owner of the tag leaving the pipeline
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         core_rdata_q  <= '0;
         core_rvalid_q <= 1'b0;
      end else begin
         host_rvalid_q <= tag_q[LAST_STAGE].valid & ~tag_q[LAST_STAGE].to_core;
         core_rvalid_q <= tag_q[LAST_STAGE].valid &  tag_q[LAST_STAGE].to_core;
         if (tag_q[LAST_STAGE].valid & ~tag_q[LAST_STAGE].to_core) begin
            host_rdata_q <= bus.bram_rdata_in;
         end
         if (tag_q[LAST_STAGE].valid & tag_q[LAST_STAGE].to_core) begin
            core_rdata_q <= bus.bram_rdata_in;
         end
      end
   end

   // Ownership FSM; HANDBACK is a guard cycle that absorbs a trailing comms strobe
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         preempted_q <= 1'b0;
      end else begin
         preempted_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.host_lock_in) begin
                  state_q <= ST_HOST;
               end else if (core_grant & bus.core_lock_in) begin
                  state_q <= ST_CORE;
               end
            end
            ST_CORE: begin
               if (bus.host_lock_in) begin
                  state_q     <= ST_HOST;
                  preempted_q <= 1'b1;
               end else if (!bus.core_lock_in) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HOST: begin
               if (!bus.host_lock_in && !host_access) begin
                  state_q <= ST_HANDBACK;
               end
            end
            ST_HANDBACK: state_q <= ST_IDLE;
            default:     state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_STALL_COUNT_EN
   logic [31:0] stall_cnt_q;

   // Cycles the core waited with a pending request; saturates, clear beats increment
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_cnt_q <= '0;
      end else if (bus.stall_count_clr_in) begin
         stall_cnt_q <= '0;
      end else if (bus.core_req_in && !core_grant && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.core_stall_count_out = stall_cnt_q;
`endif

   assign bus.host_rdata_out     = host_rdata_q;
   assign bus.host_rvalid_out    = host_rvalid_q;
   assign bus.core_rdata_out     = core_rdata_q;
   assign bus.core_rvalid_out    = core_rvalid_q;
   assign bus.core_preempted_out = preempted_q;
   assign bus.core_grant_out     = core_grant;
   assign bus.bram_en_out        = bram_en;
   assign bus.bram_we_out        = bram_we;
   assign bus.bram_addr_out      = bram_addr;
   assign bus.bram_wdata_out     = bram_wdata;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: per-cycle ownership model plus a read-data queue per owner.
module tb_bram_port_arbiter;
   localparam int AW = 14;
   localparam int DW = 64;
   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bram_port_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .READ_LATENCY(RL)
   ) dut (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus   (bus.slave)
   );

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      logic [31:0] x;
      x = 32'(a);
      return {x * 32'h9E37_79B1, x ^ 32'hA5A5_5A5A};
   endfunction

   // Write-first BRAM with RL cycles of read latency
   logic [DW-1:0] mem [2**AW];
   bit            written [2**AW];
   logic [DW-1:0] rpipe [RL];
   always @(posedge clk) begin
      if (bus.bram_en_out) begin
         if (bus.bram_we_out) begin
            mem[bus.bram_addr_out]     <= bus.bram_wdata_out;
            written[bus.bram_addr_out] <= 1'b1;
            rpipe[0]                   <= bus.bram_wdata_out;
         end else begin
            rpipe[0] <= written[bus.bram_addr_out] ? mem[bus.bram_addr_out]
                                                   : init_word(bus.bram_addr_out);
         end
      end
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
   end
   assign bus.bram_rdata_in = rpipe[RL-1];

   // Reference model state
   typedef struct {
      int unsigned   due;
      logic [DW-1:0] data;
   } exp_t;
   exp_t          host_q[$];
   exp_t          core_q[$];
   logic [DW-1:0] shadow [int unsigned];
   bit            m_host_own, m_guard, m_core_own, m_pre, m_last_grant;
   logic [31:0]   m_stall;
   logic [DW-1:0] last_host, last_core;

   function automatic logic [DW-1:0] read_shadow(input logic [AW-1:0] a);
      if (shadow.exists(32'(a))) return shadow[32'(a)];
      return init_word(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic reset_model();
      host_q.delete();
      core_q.delete();
      m_host_own = 0; m_guard = 0; m_core_own = 0; m_pre = 0; m_last_grant = 0;
      m_stall = '0;
      last_host = '0;
      last_core = '0;
   endtask

   task automatic idle_inputs();
      bus.host_lock_in  = 1'b0;
      bus.host_addr_in  = '0;
      bus.host_wdata_in = '0;
      bus.host_we_in    = 1'b0;
      bus.host_re_in    = 1'b0;
      bus.core_req_in   = 1'b0;
      bus.core_we_in    = 1'b0;
      bus.core_addr_in  = '0;
      bus.core_wdata_in = '0;
      bus.core_lock_in  = 1'b0;
`ifdef ARB_STALL_COUNT_EN
      bus.stall_count_clr_in = 1'b0;
`endif
   endtask

   // Compare this cycle's combinational port against the model, push expected reads, advance model
   task automatic check_cycle();
      logic        hacc, g;
      int unsigned due;
      hacc = bus.host_we_in | bus.host_re_in;
      g    = bus.core_req_in & ~bus.host_lock_in & ~hacc & ~m_host_own & ~m_guard;
      check("core_grant", 64'(bus.core_grant_out), 64'(g));
      check("bram_en", 64'(bus.bram_en_out), 64'(hacc | g));
      if (hacc | g) begin
         check("bram_we", 64'(bus.bram_we_out), 64'(hacc ? bus.host_we_in : bus.core_we_in));
         check("bram_addr", 64'(bus.bram_addr_out), 64'(hacc ? bus.host_addr_in : bus.core_addr_in));
         if (bus.bram_we_out)
            check("bram_wdata", bus.bram_wdata_out, hacc ? bus.host_wdata_in : bus.core_wdata_in);
      end
      check("core_preempted", 64'(bus.core_preempted_out), 64'(m_pre));
`ifdef ARB_STALL_COUNT_EN
      check("stall_count", 64'(bus.core_stall_count_out), 64'(m_stall));
      if (bus.stall_count_clr_in) m_stall = '0;
      else if (bus.core_req_in && !g && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      due = cyc + RL + 1;
      if (hacc) begin
         if (bus.host_we_in) shadow[32'(bus.host_addr_in)] = bus.host_wdata_in;
         else host_q.push_back('{due, read_shadow(bus.host_addr_in)});
      end else if (g) begin
         if (bus.core_we_in) shadow[32'(bus.core_addr_in)] = bus.core_wdata_in;
         else core_q.push_back('{due, read_shadow(bus.core_addr_in)});
      end
      m_pre = 0;
      if (m_guard) m_guard = 0;
      else if (m_host_own) begin
         if (!bus.host_lock_in && !hacc) begin m_host_own = 0; m_guard = 1; end
      end else if (bus.host_lock_in) begin
         m_pre = m_core_own; m_core_own = 0; m_host_own = 1;
      end else if (m_core_own) begin
         if (!bus.core_lock_in) m_core_own = 0;
      end else if (g && bus.core_lock_in) m_core_own = 1;
      m_last_grant = g;
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      reset_model();
      @(negedge clk);
      check("rst_host_rvalid", 64'(bus.host_rvalid_out), 64'd0);
      check("rst_core_rvalid", 64'(bus.core_rvalid_out), 64'd0);
      check("rst_host_rdata", bus.host_rdata_out, 64'd0);
      check("rst_core_rdata", bus.core_rdata_out, 64'd0);
      check("rst_grant", 64'(bus.core_grant_out), 64'd0);
      check("rst_preempted", 64'(bus.core_preempted_out), 64'd0);
      check("rst_bram_en", 64'(bus.bram_en_out), 64'd0);
      check("rst_bram_we", 64'(bus.bram_we_out), 64'd0);
      check("rst_bram_addr", 64'(bus.bram_addr_out), 64'd0);
      check("rst_bram_wdata", bus.bram_wdata_out, 64'd0);
`ifdef ARB_STALL_COUNT_EN
      check("rst_stall_count", 64'(bus.core_stall_count_out), 64'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic core_cmd(input logic req, input logic we, input logic [AW-1:0] a, input logic lock);
      bus.core_req_in   = req;
      bus.core_we_in    = we;
      bus.core_addr_in  = a;
      bus.core_wdata_in = {$urandom, $urandom};
      bus.core_lock_in  = lock;
   endtask

   task automatic host_cmd(input logic lock, input logic we, input logic re, input logic [AW-1:0] a);
      bus.host_lock_in  = lock;
      bus.host_we_in    = we;
      bus.host_re_in    = re;
      bus.host_addr_in  = a;
      bus.host_wdata_in = {$urandom, $urandom};
   endtask

   // Monitor: pop and compare on every rvalid; rdata must hold between pulses
   exp_t he, ce;
   always @(negedge clk) begin
      if (rst_n) begin
         if (host_q.size() > 0 && host_q[0].due < cyc) begin
            check("host_rvalid_missing", 64'(host_q[0].due), 64'(cyc));
            he = host_q.pop_front();
         end
         if (core_q.size() > 0 && core_q[0].due < cyc) begin
            check("core_rvalid_missing", 64'(core_q[0].due), 64'(cyc));
            ce = core_q.pop_front();
         end
         if (bus.host_rvalid_out) begin
            if (host_q.size() == 0) check("host_rvalid_spurious", 64'd1, 64'd0);
            else begin
               he = host_q.pop_front();
               check("host_rvalid_cycle", 64'(cyc), 64'(he.due));
               check("host_rdata", bus.host_rdata_out, he.data);
               last_host = he.data;
            end
         end else check("host_rdata_hold", bus.host_rdata_out, last_host);
         if (bus.core_rvalid_out) begin
            if (core_q.size() == 0) check("core_rvalid_spurious", 64'd1, 64'd0);
            else begin
               ce = core_q.pop_front();
               check("core_rvalid_cycle", 64'(cyc), 64'(ce.due));
               check("core_rdata", bus.core_rdata_out, ce.data);
               last_core = ce.data;
            end
         end else check("core_rdata_hold", bus.core_rdata_out, last_core);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      do_reset();

      // Core-only read of address 5
      core_cmd(1, 0, 14'h0005, 0); tick();
      idle_inputs(); repeat (5) tick();

      // Host write wins over a pending core read; core granted next cycle
      host_cmd(0, 1, 0, 14'h0010); core_cmd(1, 0, 14'h0010, 0); tick();
      host_cmd(0, 0, 0, 14'h0); tick();
      idle_inputs(); repeat (5) tick();

      // Preemption of a locked core burst
      core_cmd(1, 0, 14'h0007, 1); tick();
      core_cmd(1, 0, 14'h0008, 1); tick();
      host_cmd(1, 0, 1, 14'h0008); core_cmd(1, 0, 14'h0009, 1); tick();
      host_cmd(1, 1, 0, 14'h0009); tick();
      host_cmd(1, 0, 0, 14'h0); repeat (3) tick();
      host_cmd(0, 0, 0, 14'h0); repeat (4) tick();
      idle_inputs(); repeat (5) tick();

      // Interleaved host/core/host reads
      host_cmd(0, 0, 1, 14'h0001); core_cmd(1, 0, 14'h0002, 0); tick();
      host_cmd(0, 0, 0, 14'h0); tick();
      host_cmd(0, 0, 1, 14'h0003); bus.core_req_in = 1'b0; tick();
      idle_inputs(); repeat (5) tick();

      // Simultaneous host write and read: write wins, no read data returned
      host_cmd(0, 1, 1, 14'h0004); tick();
      host_cmd(0, 0, 1, 14'h0004); tick();
      idle_inputs(); repeat (5) tick();

      // Async reset one cycle after a core read is accepted
      core_cmd(1, 0, 14'h0006, 0); tick();
      idle_inputs(); #2;
      do_reset();
      repeat (6) tick();

`ifdef ARB_STALL_COUNT_EN
      // Core stalled through a host lock window, then cleared while still stalling
      core_cmd(1, 0, 14'h000A, 0);
      host_cmd(1, 0, 0, 14'h0); repeat (10) tick();
      host_cmd(0, 0, 0, 14'h0); repeat (3) tick();
      idle_inputs(); tick();
      core_cmd(1, 0, 14'h000B, 0); host_cmd(1, 0, 0, 14'h0);
      bus.stall_count_clr_in = 1'b1; tick();
      bus.stall_count_clr_in = 1'b0; tick();
      idle_inputs(); repeat (5) tick();
`endif

      // Randomized traffic over a small address window to hit read-after-write cases
      for (int n = 0; n < 1500; n++) begin
         if (bus.host_lock_in) bus.host_lock_in = ($urandom_range(0, 4) != 0);
         else                  bus.host_lock_in = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) < (bus.host_lock_in ? 6 : 2)) begin
            case ($urandom_range(0, 2))
               0:       begin bus.host_we_in = 1'b1; bus.host_re_in = 1'b0; end
               1:       begin bus.host_we_in = 1'b0; bus.host_re_in = 1'b1; end
               default: begin bus.host_we_in = 1'b1; bus.host_re_in = 1'b1; end
            endcase
         end else begin
            bus.host_we_in = 1'b0;
            bus.host_re_in = 1'b0;
         end
         bus.host_addr_in  = 14'($urandom_range(0, 31));
         bus.host_wdata_in = {$urandom, $urandom};
         if (!(bus.core_req_in && !m_last_grant)) begin
            bus.core_req_in   = 1'($urandom_range(0, 1));
            bus.core_we_in    = ($urandom_range(0, 2) == 0);
            bus.core_addr_in  = 14'($urandom_range(0, 31));
            bus.core_wdata_in = {$urandom, $urandom};
         end
         if ($urandom_range(0, 5) == 0) bus.core_lock_in = ~bus.core_lock_in;
`ifdef ARB_STALL_COUNT_EN
         bus.stall_count_clr_in = ($urandom_range(0, 49) == 0);
`endif
         tick();
      end

      idle_inputs();
      repeat (8) tick();
      check("host_q_drained", 64'(host_q.size()), 64'd0);
      check("core_q_drained", 64'(core_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
